// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory initiator: FSM state, port ownership and
// the default bus widths shared with the program/data memory.
package mem_access_ctrl_pkg;

    localparam int BITS_DATA_DEF = 32;
    localparam int BITS_ADDR_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request channels (instruction fetch and load/store) of the memory
// initiator. The master modport is the CPU; the slave modport is the controller.
interface mem_access_ctrl_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
);

    // Handshake: a requester raises *_req with stable address/data and holds it
    // until the matching one-cycle *_ack; read data (and d_err) is valid only
    // in the ack cycle and the requester must drop or change the request by the
    // second posedge after the ack is seen, otherwise it is taken as a new access.
    logic                 if_req;
    logic [BITS_ADDR-1:0] if_addr;
    logic                 if_ack;
    logic [BITS_DATA-1:0] if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [BITS_ADDR-1:0] d_addr;
    logic [BITS_DATA-1:0] d_wdata;
    logic                 d_ack;
    logic [BITS_DATA-1:0] d_rdata;
    logic                 d_err;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_err
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch and load/store onto a single-port memory with
// asynchronous read and negedge write; one access every three cycles.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          BITS_DATA = BITS_DATA_DEF,
    parameter int          BITS_ADDR = BITS_ADDR_DEF,
    parameter int unsigned RO_LIMIT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_ctrl_if.slave     bus,
    output logic                 busy,
    output state_t               dbg_state,
    output logic [BITS_ADDR-1:0] mem_address,
    output logic [BITS_DATA-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_data_out
);

    // One extra bit so RO_LIMIT may cover the whole address space.
    localparam logic [BITS_ADDR:0] RO_LIM = (BITS_ADDR + 1)'(RO_LIMIT);

    state_t               state;
    owner_t               owner;
    logic                 is_store;
    logic                 err_pend;
    logic                 if_ack_q;
    logic [BITS_DATA-1:0] if_rdata_q;
    logic                 d_ack_q;
    logic [BITS_DATA-1:0] d_rdata_q;
    logic                 d_err_q;

    logic grant_d;
    logic grant_if;
    logic ro_hit;

    // Data port has fixed priority; a losing fetch simply waits for the next IDLE.
    assign grant_d  = bus.d_req;
    assign grant_if = bus.if_req && !bus.d_req;

    assign ro_hit = ({1'b0, bus.d_addr} < RO_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            is_store    <= 1'b0;
            err_pend    <= 1'b0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner       <= OWN_D;
                        mem_address <= bus.d_addr;
                        is_store    <= bus.d_we;
                        if (bus.d_we && !ro_hit) begin
                            mem_write   <= 1'b1;
                            mem_data_in <= bus.d_wdata;
                            err_pend    <= 1'b0;
                        end else begin
                            mem_write <= 1'b0;
                            err_pend  <= bus.d_we;
                        end
                        state <= ST_ACCESS;
                    end else if (grant_if) begin
                        owner       <= OWN_IF;
                        mem_address <= bus.if_addr;
                        is_store    <= 1'b0;
                        err_pend    <= 1'b0;
                        mem_write   <= 1'b0;
                        state       <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // The memory has already written at this cycle's negedge.
                    mem_write <= 1'b0;
                    if (owner == OWN_D) begin
                        d_ack_q <= 1'b1;
                        d_err_q <= err_pend;
                        if (!is_store) begin
                            d_rdata_q <= mem_data_out;
                        end
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= mem_data_out;
                    end
                    state <= ST_ACK;
                end

                ST_ACK: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    d_err_q  <= 1'b0;
                    err_pend <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    mem_write <= 1'b0;
                    if_ack_q  <= 1'b0;
                    d_ack_q   <= 1'b0;
                    d_err_q   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule
